// File: rtl/my_ram_param.sv
// Parametrised Hack-style data RAM with a hardware zero sweep after reset or on request.
// Reads are combinational and writes happen on the rising edge; accesses are blocked while a sweep runs.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | sweep in progress: one word zeroed per edge, user access blocked
// READY | normal RAM operation; clear=1 restarts a sweep
module my_ram_param #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = in;
    case (state_q)
      CLEAR: begin
        // Terminal detect on the last word so ptr never needs an extra bit.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == PTR_LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      READY: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (load) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // The array carries no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign busy = (state_q == CLEAR);
  assign out  = busy ? '0 : mem_q[addr];

endmodule

// File: tb/tb_my_ram_param.sv
// Directed bench for my_ram_param: a 16-word instance for the behaviour checks and
// a default-size instance for the 16384-edge sweep length.
module tb_my_ram_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic [3:0]  addr;
  logic        load;
  logic        clear;
  logic [15:0] dout;
  logic        busy;

  logic        rst14_n;
  logic [15:0] din14;
  logic [13:0] addr14;
  logic        load14;
  logic        clear14;
  logic [15:0] dout14;
  logic        busy14;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  my_ram_param #(.WIDTH(16), .ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(din), .addr(addr), .load(load),
    .clear(clear), .out(dout), .busy(busy)
  );

  my_ram_param dut14 (
    .clk(clk), .rst_n(rst14_n), .in(din14), .addr(addr14), .load(load14),
    .clear(clear14), .out(dout14), .busy(busy14)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 2 ns past it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    addr = a; din = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("busy_in_reset", 64'(busy), 64'(1'b1));
    chk("out_in_reset", 64'(dout), 64'(16'd0));
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      chk(tag, 64'(dout), 64'(16'd0));
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b1; din = '0; addr = '0; load = 1'b0; clear = 1'b0;
    rst14_n = 1'b0; din14 = '0; addr14 = '0; load14 = 1'b0; clear14 = 1'b0;
    step();

    // Reset sweep, with a write attempt to addr 3 while busy
    pulse_reset();
    chk("busy_after_release", 64'(busy), 64'(1'b1));
    n = 0;
    while (busy && n < 40) begin
      if (n == 2) begin addr = 4'd3; din = 16'hFFFF; load = 1'b1; end
      if (n == 6) load = 1'b0;
      if (n == 4) chk("out_zero_while_busy", 64'(dout), 64'(16'd0));
      step();
      n++;
    end
    load = 1'b0;
    chk("sweep_len_reset", 64'(n), 64'(16));
    addr = 4'd3;
    #1;
    chk("blocked_write_addr3", 64'(dout), 64'(16'd0));
    check_all_zero("zero_after_reset");

    // Boundary writes and combinational reads
    wr(4'd0, 16'd2);
    wr(4'b1011, 16'd9);
    wr(4'b1111, 16'd1);
    addr = 4'd0;    #1; chk("rd_addr0", 64'(dout), 64'(16'd2));
    addr = 4'b1011; #1; chk("rd_addr11", 64'(dout), 64'(16'd9));
    addr = 4'b1111; #1; chk("rd_addr15", 64'(dout), 64'(16'd1));
    addr = 4'b0001; #1; chk("rd_addr1", 64'(dout), 64'(16'd0));

    // No write bypass: old value until the edge
    addr = 4'd5; din = 16'd7; load = 1'b1;
    #1;
    chk("hack_before_edge", 64'(dout), 64'(16'd0));
    step();
    chk("hack_after_edge", 64'(dout), 64'(16'd7));
    din = 16'd3; load = 1'b0;
    step();
    chk("hack_load0_keeps", 64'(dout), 64'(16'd7));

    // clear command with a concurrent write, plus an ignored second clear
    for (int a = 0; a < 16; a++) wr(4'(a), 16'(a + 100));
    addr = 4'd9; #1;
    chk("fill_addr9", 64'(dout), 64'(16'd109));
    addr = 4'd2; din = 16'd55; load = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; load = 1'b0;
    chk("busy_after_clear", 64'(busy), 64'(1'b1));
    chk("out_zero_after_clear", 64'(dout), 64'(16'd0));
    n = 0;
    while (busy && n < 40) begin
      clear = (n == 5);
      step();
      n++;
    end
    clear = 1'b0;
    chk("sweep_len_clear", 64'(n), 64'(16));
    check_all_zero("zero_after_clear");

    // Async reset mid-sweep restarts the count
    wr(4'd6, 16'hABCD);
    pulse_reset();
    for (int i = 0; i < 8; i++) step();
    chk("busy_mid_sweep", 64'(busy), 64'(1'b1));
    pulse_reset();
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("sweep_len_mid_reset", 64'(n), 64'(16));
    addr = 4'd6; #1;
    chk("zero_addr6_after_resweep", 64'(dout), 64'(16'd0));

    // Default size: 16384-edge sweep
    chk("busy14_in_reset", 64'(busy14), 64'(1'b1));
    rst14_n = 1'b1;
    n = 0;
    while (busy14 && n < 20000) begin
      step();
      n++;
    end
    chk("sweep_len_14", 64'(n), 64'(16384));
    addr14 = 14'h3FFF; #1;
    chk("rd14_last_zero", 64'(dout14), 64'(16'd0));
    addr14 = 14'd100; din14 = 16'h1234; load14 = 1'b1;
    step();
    load14 = 1'b0;
    chk("rd14_write", 64'(dout14), 64'(16'h1234));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
